// File: rtl/mc_control_pkg.sv
// Shared MIPS definitions: opcodes, control-FSM state encodings and datapath select codes.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EXEC  = 4'd10,
        S_IMM_WB    = 4'd11
    } state_e;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [1:0] MTR_ALUOUT  = 2'd0;
    localparam logic [1:0] MTR_MDR     = 2'd1;
    localparam logic [1:0] MTR_PC      = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW)   ||
               (op == OP_BEQ)   || (op == OP_BNE) || (op == OP_ADDI) ||
               (op == OP_J)     || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
interface mc_control_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               mem_ready;
    logic               pc_we;
    logic               iord;
    logic               mem_re;
    logic               mem_we;
    logic               ir_we;
    logic               reg_we;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_src;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_we, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_we, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_src, illegal, state
    );
endinterface

// File: rtl/mc_control.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/memory/writeback sequencing
// with Moore-decoded datapath controls and optional memory wait states.
module mc_control
    import mips_defs::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int STATE_W     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mc_control_if.master ctrl
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       mem_done;

    // funct only feeds the ALU decoder in the datapath
    logic unused_funct;
    assign unused_funct = ^ctrl.funct;

    assign mem_done = MEM_WAIT_EN ? ctrl.mem_ready : 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH:     if (mem_done) state_d = S_DECODE;
            S_DECODE: begin
                op_d = ctrl.opcode;
                case (ctrl.opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_IMM_EXEC;
                    OP_J, OP_JAL:  state_d = S_JUMP;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_done) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_done) state_d = S_FETCH;
            S_EXEC:      state_d = S_ALU_WB;
            S_IMM_EXEC:  state_d = S_IMM_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    // While in reset the decode sees FETCH so selects settle early; enables are masked below.
    state_e dec_st;
    logic   pc_we_raw, mem_re_raw, mem_we_raw, ir_we_raw, reg_we_raw, illegal_raw;

    assign dec_st = rst_i ? S_FETCH : state_q;

    always_comb begin
        pc_we_raw       = 1'b0;
        mem_re_raw      = 1'b0;
        mem_we_raw      = 1'b0;
        ir_we_raw       = 1'b0;
        reg_we_raw      = 1'b0;
        illegal_raw     = 1'b0;
        ctrl.iord       = 1'b0;
        ctrl.reg_dst    = REG_DST_RT;
        ctrl.mem_to_reg = MTR_ALUOUT;
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.pc_src     = PCSRC_ALU;
        case (dec_st)
            S_FETCH: begin
                mem_re_raw     = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ir_we_raw      = mem_done;
                pc_we_raw      = mem_done;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                illegal_raw    = ~op_is_legal(ctrl.opcode);
            end
            S_MEM_ADDR, S_IMM_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_re_raw = 1'b1;
                ctrl.iord  = 1'b1;
            end
            S_MEM_WB: begin
                reg_we_raw      = 1'b1;
                ctrl.mem_to_reg = MTR_MDR;
            end
            S_MEM_WRITE: begin
                mem_we_raw = 1'b1;
                ctrl.iord  = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALU_WB: begin
                reg_we_raw   = 1'b1;
                ctrl.reg_dst = REG_DST_RD;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                pc_we_raw      = ((op_q == OP_BEQ) &&  ctrl.zero) ||
                                 ((op_q == OP_BNE) && !ctrl.zero);
            end
            S_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                pc_we_raw   = 1'b1;
                if (op_q == OP_JAL) begin
                    reg_we_raw      = 1'b1;
                    ctrl.reg_dst    = REG_DST_R31;
                    ctrl.mem_to_reg = MTR_PC;
                end
            end
            S_IMM_WB:    reg_we_raw = 1'b1;
            default: ;
        endcase
    end

    assign ctrl.pc_we   = pc_we_raw   & ~rst_i;
    assign ctrl.mem_re  = mem_re_raw  & ~rst_i;
    assign ctrl.mem_we  = mem_we_raw  & ~rst_i;
    assign ctrl.ir_we   = ir_we_raw   & ~rst_i;
    assign ctrl.reg_we  = reg_we_raw  & ~rst_i;
    assign ctrl.illegal = illegal_raw & ~rst_i;
    assign ctrl.state   = STATE_W'(state_q);

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle main control FSM for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the write enable and destination/source selects of the register file, plus the PC, IR, memory and ALU mux controls.
- Sits directly upstream of the register file: its reg_we/reg_dst/mem_to_reg outputs gate every register-file write.

Parameters:
- MEM_WAIT_EN, 1, when 1 FETCH/MEM_READ/MEM_WRITE stall until mem_ready=1; when 0 mem_ready is ignored (single-cycle memory).
- STATE_W, 4, width of the state register and of the state debug output.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_we  out  1  PC load
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- ir_we  out  1  IR load
- reg_we  out  1  register-file write enable
- reg_dst  out  2  write-register select: 0=rt, 1=rd, 2=r31
- mem_to_reg  out  2  write-data select: 0=ALUOut, 1=MDR, 2=PC
- alu_src_a  out  1  ALU A select: 0=PC, 1=A
- alu_src_b  out  2  ALU B select: 0=B, 1=const 4, 2=sign-extended imm, 3=imm<<2
- alu_op  out  2  ALU operation: 0=add, 1=sub, 2=use funct
- pc_src  out  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target
- illegal  out  1  one-cycle pulse on an unknown opcode
- state  out  STATE_W  current state (debug)

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11.
- Reset:
  - rst=1 at a clock edge: state<=FETCH, op_q<=0.
  - While rst=1, pc_we, ir_we, mem_re, mem_we, reg_we and illegal are forced to 0.
  - Select outputs take their FETCH values.
- Outputs are a Moore decode of state. The exceptions are pc_we in BRANCH, and the mem_ready gating of pc_we/ir_we in FETCH. All selects not listed for a state are 0.
- FETCH:
  - Outputs: mem_re=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - ir_we=pc_we=mem_ready when MEM_WAIT_EN=1, else both =1.
  - Advance to DECODE only when the access completes; otherwise hold.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut).
  - op_q<=opcode.
  - Next state by opcode:
    - 000000 (R-type) -> EXEC
    - 100011 (lw), 101011 (sw) -> MEM_ADDR
    - 000100 (beq), 000101 (bne) -> BRANCH
    - 001000 (addi) -> IMM_EXEC
    - 000010 (j), 000011 (jal) -> JUMP
    - any other opcode: illegal=1 for this cycle, next state FETCH
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=2, alu_op=0.
  - Next: MEM_READ if op_q=lw, else MEM_WRITE.
- MEM_READ:
  - Outputs: mem_re=1, iord=1.
  - Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_we=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WRITE:
  - Outputs: mem_we=1, iord=1.
  - Hold until mem_ready, then go to FETCH.
  - mem_we stays high for every stall cycle.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Next ALU_WB.
- ALU_WB:
  - Outputs: reg_we=1, reg_dst=1, mem_to_reg=0. Next FETCH.
  - funct is passed only to the ALU decoder; the FSM does not use it.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1.
  - pc_we = (op_q=beq & zero) | (op_q=bne & ~zero).
  - Next FETCH.
- JUMP:
  - Outputs: pc_src=2, pc_we=1.
  - If op_q=jal: reg_we=1, reg_dst=2, mem_to_reg=2. PC already holds PC+4, so r31<=PC+4 on the same edge the PC loads the target.
  - Next FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=2, alu_op=0. Next IMM_WB.
- IMM_WB: reg_we=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- Latency with zero wait states: lw 5 cycles; sw, R-type and addi 4 cycles; beq, bne, j and jal 3 cycles. Each stall cycle adds one.
- Reset mid-instruction aborts the instruction: no write enable fires on or after the reset edge.
- Unused state encodings 12–15 go to FETCH on the next edge with all enables 0.

Decomposition:
- Shared package mips_defs holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL)
  - state encodings
  - select encodings for reg_dst, mem_to_reg, alu_src_b, alu_op and pc_src
- Single module, no sub-module; next-state and output decode are separate combinational blocks.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1 -> state=0 and all enables 0 during reset; cycle 1 after release has ir_we=pc_we=1.
- lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_we=1 only in state 4 with reg_dst=0, mem_to_reg=1.
- sw with mem_ready low for 3 cycles in MEM_WRITE -> mem_we high for 4 consecutive cycles; reg_we never asserted; returns to FETCH.
- beq with zero=1, then bne with zero=1 -> pc_we=1 in BRANCH for beq; pc_we=0 for bne; each takes 3 cycles.
- jal (000011) -> JUMP asserts pc_we=1, reg_we=1, reg_dst=2, mem_to_reg=2, pc_src=2 in the same cycle.
- opcode 111111 -> illegal pulses for 1 cycle in DECODE, then FETCH; also assert rst in EXEC of an R-type -> no reg_we, state=0 next cycle.
